// File: rtl/serial_magnitude_comparator.sv
// Bit-serial magnitude comparator: one bit position per clock, MSB- or LSB-first scan.
// Result code {y,z}: 00 none, 01 A==B, 10 A>B, 11 B>A; f flags A>=B.
module serial_magnitude_comparator #(
  parameter int WIDTH      = 16,
  parameter int MSB_FIRST  = 1,
  parameter int EARLY_EXIT = 1,
  localparam int BW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             y,
  output logic             z,
  output logic             f,
  output logic [BW-1:0]    bits_used
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] IDX_FIRST = (MSB_FIRST != 0) ? IW'(WIDTH - 1) : '0;
  localparam logic [IW-1:0] IDX_LAST  = (MSB_FIRST != 0) ? '0 : IW'(WIDTH - 1);
  localparam logic [1:0] RES_EQ  = 2'b01;
  localparam logic [1:0] RES_AGT = 2'b10;
  localparam logic [1:0] RES_BGT = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_COMPARE, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [1:0]       res_q, res_d;
  logic [BW-1:0]    bits_q, bits_d;

  logic       a_bit, b_bit, differ, last_bit, early_stop;
  logic [1:0] bit_res;

  assign a_bit      = a_q[idx_q];
  assign b_bit      = b_q[idx_q];
  assign differ     = a_bit ^ b_bit;
  assign bit_res    = a_bit ? RES_AGT : RES_BGT;
  assign last_bit   = (idx_q == IDX_LAST);
  assign early_stop = (MSB_FIRST != 0) && (EARLY_EXIT != 0) && differ;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      res_q   <= 2'b00;
      bits_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      bits_q  <= bits_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_COMPARE;
      S_COMPARE: if (last_bit || early_stop) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    idx_d  = idx_q;
    res_d  = res_q;
    bits_d = bits_q;
    if (state_q == S_IDLE && start) begin
      a_d    = A;
      b_d    = B;
      idx_d  = IDX_FIRST;
      res_d  = RES_EQ;
      bits_d = '0;
    end else if (state_q == S_COMPARE) begin
      bits_d = bits_q + BW'(1);
      // MSB-first keeps the first difference; LSB-first lets higher bits overwrite.
      if (differ && ((MSB_FIRST == 0) || (res_q == RES_EQ)))
        res_d = bit_res;
      if (!last_bit)
        idx_d = (MSB_FIRST != 0) ? (idx_q - IW'(1)) : (idx_q + IW'(1));
    end
  end

  always_comb begin
    busy      = (state_q == S_COMPARE);
    done      = (state_q == S_DONE);
    {y, z}    = busy ? 2'b00 : res_q;
    f         = !busy && ((res_q == RES_EQ) || (res_q == RES_AGT));
    bits_used = bits_q;
  end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Scoreboard bench: four comparator configurations share stimulus; a reference
// model queues expected results which are popped on each done pulse.
module tb_serial_magnitude_comparator;

  typedef struct {
    logic [1:0] yz;
    logic       f;
    int         bits;
    int         lat;
    int         t0;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;

  logic [3:0]  busy_w, done_w, y_w, z_w, f_w;
  logic [4:0]  bits_w [4];
  logic        bits3;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  int cfg_w     [4] = '{16, 16, 16, 1};
  bit cfg_msb   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  bit cfg_early [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

  exp_t       exp_q [4][$];
  exp_t       mon_e;
  logic [1:0] last_yz0;
  int         last_bits0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_magnitude_comparator #(.WIDTH(16), .MSB_FIRST(1), .EARLY_EXIT(1)) u_msb (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .busy(busy_w[0]), .done(done_w[0]), .y(y_w[0]), .z(z_w[0]), .f(f_w[0]),
    .bits_used(bits_w[0]));

  serial_magnitude_comparator #(.WIDTH(16), .MSB_FIRST(0), .EARLY_EXIT(1)) u_lsb (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .busy(busy_w[1]), .done(done_w[1]), .y(y_w[1]), .z(z_w[1]), .f(f_w[1]),
    .bits_used(bits_w[1]));

  serial_magnitude_comparator #(.WIDTH(16), .MSB_FIRST(1), .EARLY_EXIT(0)) u_full (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .busy(busy_w[2]), .done(done_w[2]), .y(y_w[2]), .z(z_w[2]), .f(f_w[2]),
    .bits_used(bits_w[2]));

  serial_magnitude_comparator #(.WIDTH(1), .MSB_FIRST(1), .EARLY_EXIT(1)) u_w1 (
    .clk(clk), .rst(rst), .start(start), .A(A[0:0]), .B(B[0:0]),
    .busy(busy_w[3]), .done(done_w[3]), .y(y_w[3]), .z(z_w[3]), .f(f_w[3]),
    .bits_used(bits3));

  assign bits_w[3] = {4'b0000, bits3};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Highest differing bit decides; only MSB-first early exit shortens the scan.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input int w, input bit msb, input bit early);
    exp_t e;
    int   hi = -1;
    for (int i = w - 1; i >= 0; i--)
      if (hi < 0 && a[i] != b[i]) hi = i;
    if (hi < 0) e.yz = 2'b01;
    else        e.yz = a[hi] ? 2'b10 : 2'b11;
    e.f    = (e.yz != 2'b11);
    e.bits = (msb && early && hi >= 0) ? (w - hi) : w;
    e.lat  = e.bits + 1;
    e.t0   = 0;
    return e;
  endfunction

  function automatic int pending();
    int n = 0;
    for (int k = 0; k < 4; k++) n += exp_q[k].size();
    return n;
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (done_w[k]) begin
        if (exp_q[k].size() == 0) begin
          check($sformatf("u%0d_spurious_done", k), 1, 0);
        end else begin
          mon_e = exp_q[k].pop_front();
          check($sformatf("u%0d_yz", k), {y_w[k], z_w[k]}, mon_e.yz);
          check($sformatf("u%0d_f", k), f_w[k], mon_e.f);
          check($sformatf("u%0d_bits", k), bits_w[k], mon_e.bits);
          check($sformatf("u%0d_lat", k), cyc - mon_e.t0, mon_e.lat);
          check($sformatf("u%0d_busy_at_done", k), busy_w[k], 0);
          $display("txn u%0d yz=%b f=%b bits=%0d lat=%0d", k, {y_w[k], z_w[k]},
                   f_w[k], bits_w[k], cyc - mon_e.t0);
          if (k == 0) begin
            last_yz0   = mon_e.yz;
            last_bits0 = mon_e.bits;
          end
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < 4; k++)
      check($sformatf("%s_u%0d", tag, k),
            {busy_w[k], done_w[k], y_w[k], z_w[k], f_w[k], bits_w[k]}, 0);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input int rst_at, input bit poke);
    exp_t e;
    int   t0;
    int   n;
    int   lat0;
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    t0 = cyc;
    lat0 = 0;
    for (int k = 0; k < 4; k++) begin
      e = model(a, b, cfg_w[k], cfg_msb[k], cfg_early[k]);
      e.t0 = t0;
      if (k == 0) lat0 = e.lat;
      if (rst_at == 0 || e.lat <= rst_at) exp_q[k].push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    if (rst_at > 0) begin
      repeat (rst_at - 1) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_reset_outputs("abort_reset");
      check("abort_pending", pending(), 0);
    end else begin
      n = 0;
      while (pending() > 0 && n < 60) begin
        @(negedge clk);
        n++;
        if (n == 1) begin
          if (lat0 > 2)
            check("u0_busy_mid", {busy_w[0], y_w[0], z_w[0], f_w[0]}, 4'b1000);
          if (poke) begin
            start = 1'b1;
            A = ~a;
            B = ~b;
          end
        end else if (n == 2) begin
          start = 1'b0;
        end
      end
      start = 1'b0;
      check("drain_timeout", pending(), 0);
      @(negedge clk);
      check("u0_hold_yz", {y_w[0], z_w[0]}, last_yz0);
      check("u0_hold_bits", bits_w[0], last_bits0);
    end
  endtask

  initial begin
    logic [15:0] ra, rb;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    run_op(16'hDAB5, 16'hDABF, 0, 1'b0);
    run_op(16'h1234, 16'h1234, 0, 1'b0);
    run_op(16'h8000, 16'h7FFF, 0, 1'b0);
    run_op(16'h0000, 16'h0001, 0, 1'b0);
    run_op(16'hFFFF, 16'h0000, 0, 1'b1);
    run_op(16'hDAB5, 16'hDABF, 5, 1'b0);
    run_op(16'h00F0, 16'h00E1, 0, 1'b1);
    run_op(16'h0001, 16'h0000, 0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      ra = 16'($urandom);
      rb = ra ^ (16'h0001 << $urandom_range(0, 15));
      if (i % 3 == 0) rb = 16'($urandom);
      run_op(ra, rb, 0, i[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=%0d want=0", pending());
    $fatal(1, "timeout");
  end

endmodule
